// File: rtl/cpu_types_pkg.sv
// ============================================================================
//  Module : cpu_types_pkg
//  Brief  : Shared types for the instruction cache: FSM state encoding and
//           the fetch-address field split (tag / idx / byte offset).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  // Default number of icache frames shared by the CPU build.
  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IW    = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 32 - ICACHE_IW - 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  // Word-aligned fetch address split for the default geometry.
  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IW-1:0]    idx;
    logic [1:0]              bytoff;
  } icachef_t;

endpackage

`default_nettype wire

// File: rtl/icache_frames.sv
// ============================================================================
//  Module : icache_frames
//  Brief  : Frame storage for the direct-mapped icache. Each frame is
//           {valid, tag, data}. One combinational read port, one write port.
//  Ports  : clk, rst_n        clock / async active-low reset (clears valid)
//           ridx              read index
//           rvalid/rtag/rdata read frame contents
//           wen/widx/wtag/wdata  frame write (sets valid)
//           flush             clears every valid bit at the next edge
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module icache_frames #(
  parameter int NSETS = 16,
  parameter int IW    = $clog2(NSETS),
  parameter int TAG_W = 32 - IW - 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IW-1:0]    ridx,
  output logic             rvalid,
  output logic [TAG_W-1:0] rtag,
  output logic [31:0]      rdata,
  input  logic             wen,
  input  logic [IW-1:0]    widx,
  input  logic [TAG_W-1:0] wtag,
  input  logic [31:0]      wdata,
  input  logic             flush
);

  logic [NSETS-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [NSETS];
  logic [TAG_W-1:0] tag_d  [NSETS];
  logic [31:0]      data_q [NSETS];
  logic [31:0]      data_d [NSETS];

  assign rvalid = valid_q[ridx];
  assign rtag   = tag_q[ridx];
  assign rdata  = data_q[ridx];

  // A flush coinciding with a fill wins: the frame contents are written but
  // the valid bit ends up clear.
  always_comb begin
    valid_d = valid_q;
    if (wen) begin
      valid_d[widx] = 1'b1;
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  always_comb begin
    tag_d  = tag_q;
    data_d = data_q;
    if (wen) begin
      tag_d[widx]  = wtag;
      data_d[widx] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data need no reset; they are qualified by valid.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

`default_nettype wire

// File: rtl/icache.sv
// ============================================================================
//  Module : icache
//  Brief  : Direct-mapped, one-word-per-block instruction cache. Hits return
//           in the same cycle; a miss runs one blocking fill from memory and
//           the fetch is then served as a hit.
//  Ports  : CLK, nRST            clock / async active-low reset
//           imemREN, imemaddr    datapath fetch request and byte address
//           ihit, imemload       hit strobe and fetched instruction
//           flush                clear every valid bit
//           iREN, iaddr          memory read request and address
//           iwait, iload         memory busy and read data
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module icache
  import cpu_types_pkg::*;
#(
  parameter int          NSETS   = ICACHE_SETS,
  parameter logic [31:0] PC_INIT = 32'h0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int IW    = $clog2(NSETS);
  localparam int TAG_W = 32 - IW - 2;

  icache_state_t state_q, state_d;
  logic [31:0]   miss_addr_q, miss_addr_d;

  logic [IW-1:0]    req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             frm_valid;
  logic [TAG_W-1:0] frm_tag;
  logic [31:0]      frm_data;
  logic             lookup_hit;
  logic             fill_en;

  assign req_idx = imemaddr[IW+1:2];
  assign req_tag = imemaddr[31:IW+2];

  icache_frames #(
    .NSETS (NSETS),
    .IW    (IW),
    .TAG_W (TAG_W)
  ) u_frames (
    .clk    (CLK),
    .rst_n  (nRST),
    .ridx   (req_idx),
    .rvalid (frm_valid),
    .rtag   (frm_tag),
    .rdata  (frm_data),
    .wen    (fill_en),
    .widx   (miss_addr_q[IW+1:2]),
    .wtag   (miss_addr_q[31:IW+2]),
    .wdata  (iload),
    .flush  (flush)
  );

  // Raw tag compare; only meaningful in IDLE and masked by flush below.
  assign lookup_hit = imemREN && frm_valid && (frm_tag == req_tag);

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    fill_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (imemREN && !lookup_hit && !flush) begin
          miss_addr_d = imemaddr;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        // Fill always completes, even if the fetch address moved meanwhile.
        if (!iwait) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  assign ihit     = (state_q == IDLE) && lookup_hit && !flush;
  assign imemload = ihit ? frm_data : 32'h0;
  assign iREN     = (state_q == FETCH);
  assign iaddr    = iREN ? miss_addr_q : 32'h0;

  // Byte offset bits and the reserved PC_INIT carry no function here.
  logic unused_ok;
  assign unused_ok = ^{imemaddr[1:0], miss_addr_q[1:0], PC_INIT};

endmodule

`default_nettype wire
